// File: rtl/cmsdk_ahb_pkg.sv
// Shared AHB-lite encodings: transfer types, transfer sizes and response codes.
package cmsdk_ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SizeByte = 3'b000,
        SizeHalf = 3'b001,
        SizeWord = 3'b010
    } hsize_e;

    localparam logic RespOkay  = 1'b0;
    localparam logic RespError = 1'b1;

endpackage

// File: rtl/cmsdk_ahb_eg_master.sv
// Example AHB-lite master: turns a valid/ready command stream into single NONSEQ transfers
// through an address-phase / data-phase pipeline and returns one response per command.
module cmsdk_ahb_eg_master
    import cmsdk_ahb_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 12
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [1:0]           cmd_size,
    input  logic [31:0]          cmd_wdata,

    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,

    output logic [ADDRWIDTH-1:0] HADDRM,
    output logic [1:0]           HTRANSM,
    output logic [2:0]           HSIZEM,
    output logic                 HWRITEM,
    output logic [31:0]          HWDATAM,
    input  logic                 HREADYM,
    input  logic                 HRESPM,
    input  logic [31:0]          HRDATAM
);

    // Address-phase stage
    logic                 aph_valid_q;
    logic [ADDRWIDTH-1:0] aph_addr_q;
    hsize_e               aph_size_q;
    logic                 aph_write_q;
    logic [31:0]          aph_wdata_q;

    // Data-phase stage
    logic                 dph_valid_q;
    logic                 dph_write_q;
    logic [31:0]          hwdata_q;

    // Response stage
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [31:0]          rsp_rdata_q;

    logic                 cmd_accept;
    logic                 dph_done;
    hsize_e               cmd_hsize;
    logic [ADDRWIDTH-1:0] cmd_addr_aligned;

    // A new command may enter only when the address stage is empty or leaving this cycle.
    assign cmd_ready  = ~aph_valid_q | HREADYM;
    assign cmd_accept = cmd_valid & cmd_ready;
    assign dph_done   = dph_valid_q & HREADYM;

    // Decode the requested size and clear the address bits below the transfer size.
    always_comb begin
        cmd_hsize        = SizeWord;
        cmd_addr_aligned = cmd_addr;
        case (cmd_size)
            2'd0: begin
                cmd_hsize = SizeByte;
            end
            2'd1: begin
                cmd_hsize           = SizeHalf;
                cmd_addr_aligned[0] = 1'b0;
            end
            default: begin
                // Size 3 is folded onto word.
                cmd_hsize             = SizeWord;
                cmd_addr_aligned[1:0] = 2'b00;
            end
        endcase
    end

    // Address phase: load on accept, retire when the bus takes it with no follow-on command.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            aph_valid_q <= 1'b0;
            aph_addr_q  <= '0;
            aph_size_q  <= SizeByte;
            aph_write_q <= 1'b0;
            aph_wdata_q <= '0;
        end else if (cmd_accept) begin
            aph_valid_q <= 1'b1;
            aph_addr_q  <= cmd_addr_aligned;
            aph_size_q  <= cmd_hsize;
            aph_write_q <= cmd_write;
            aph_wdata_q <= cmd_wdata;
        end else if (HREADYM) begin
            aph_valid_q <= 1'b0;
        end
    end

    // Data phase: advances only on HREADYM so HWDATAM holds across wait and error cycles.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            hwdata_q    <= '0;
        end else if (HREADYM) begin
            dph_valid_q <= aph_valid_q;
            dph_write_q <= aph_write_q;
            if (aph_valid_q && aph_write_q) begin
                hwdata_q <= aph_wdata_q;
            end
        end
    end

    // Response: one-cycle pulse after each completed data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= dph_done;
            rsp_err_q   <= dph_done & (HRESPM == RespError);
            rsp_rdata_q <= (dph_done && !dph_write_q) ? HRDATAM : 32'd0;
        end
    end

    assign HTRANSM   = aph_valid_q ? TransNonseq : TransIdle;
    assign HADDRM    = aph_addr_q;
    assign HSIZEM    = aph_size_q;
    assign HWRITEM   = aph_write_q;
    assign HWDATAM   = hwdata_q;
    assign busy      = aph_valid_q | dph_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
